// File: rtl/data_ram_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the wait-state data RAM: the access FSM state
// encoding, the byte-lane select patterns treated as legal, and the common
// word/enable constants.
// Optional feature macro: DATA_RAM_ERR_EN (uses sel_is_legal()).
// -----------------------------------------------------------------------------
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    // Legal byte-lane patterns: single bytes, aligned halves, three-byte
    // groups and the full word. Bit 3 is data[31:24] (byte offset 00).
    localparam logic [3:0] SelByte0  = 4'b1000;
    localparam logic [3:0] SelByte1  = 4'b0100;
    localparam logic [3:0] SelByte2  = 4'b0010;
    localparam logic [3:0] SelByte3  = 4'b0001;
    localparam logic [3:0] SelHalfHi = 4'b1100;
    localparam logic [3:0] SelHalfLo = 4'b0011;
    localparam logic [3:0] SelTriLo  = 4'b0111;
    localparam logic [3:0] SelTriHi  = 4'b1110;
    localparam logic [3:0] SelWord   = 4'b1111;

    function automatic logic sel_is_legal(input logic [3:0] sel);
        case (sel)
            SelByte0, SelByte1, SelByte2, SelByte3,
            SelHalfHi, SelHalfLo, SelTriLo, SelTriHi,
            SelWord: sel_is_legal = 1'b1;
            default: sel_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// -----------------------------------------------------------------------------
// data_ram_bank
// Four byte-wide storage arrays with independent lane write enables and a
// registered full-word read.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (read register only)
//   we     - per-lane write enable, bit 3 -> wdata[31:24]
//   re     - load the addressed word into rdata
//   addr   - word index
//   wdata  - lane-aligned write data
//   rdata  - registered read word, held until the next re
// -----------------------------------------------------------------------------
module data_ram_bank
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int Depth = 2 ** ADDR_W;

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] mem [Depth];
        logic [7:0] rd_byte;

        // NOTE: storage has no reset branch; resetting a RAM array would
        // prevent block-RAM inference and cost a huge reset fan-out.
        always_ff @(posedge clk) begin
            if (we[lane]) begin
                // NOTE: non-blocking assignment for all clocked state so every
                // flop samples pre-edge values regardless of block ordering.
                mem[addr] <= wdata[8*lane +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_byte <= ZeroWord[7:0];
            end else if (re) begin
                rd_byte <= mem[addr];
            end
        end

        assign rdata[8*lane +: 8] = rd_byte;
    end

endmodule

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
// Single-port word RAM with a configurable number of wait states per access
// and a one-cycle completion pulse. The requester holds ce_i high until
// ack_o; dropping ce_i during the wait phase abandons the access.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   ce_i       - access request
//   we_i       - 1 = write, 0 = read
//   addr_i     - byte address (word index = addr_i[ADDR_W+1:2])
//   sel_i      - byte-lane select, bit 3 -> data[31:24]
//   data_i     - lane-aligned write data
//   data_o     - registered read word, changes only on completed reads
//   ack_o      - one-cycle completion pulse
//   stallreq_o - pipeline hold request (ce_i & ~ack_o)
//   err_o      - illegal-sel flag with ack_o (only with DATA_RAM_ERR_EN)
// Optional feature macro: DATA_RAM_ERR_EN.
// -----------------------------------------------------------------------------
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stallreq_o
`ifdef DATA_RAM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        count;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_sel;
    logic [31:0]       req_data;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        cur_sel;
    logic [31:0]       cur_data;
    logic              go;
    logic              legal;
    logic [3:0]        bank_we;
    logic              bank_re;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    // With zero wait states the access fires on the accepting edge, before the
    // request registers are loaded, so the live inputs are used in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cur_we   = req_we;
        cur_addr = req_addr;
        cur_sel  = req_sel;
        cur_data = req_data;
        if (state == IDLE) begin
            cur_we   = we_i;
            cur_addr = addr_i[ADDR_W+1:2];
            cur_sel  = sel_i;
            cur_data = data_i;
        end

        // go marks the edge that moves the FSM into DONE.
        go = 1'b0;
        if (state == IDLE && ce_i == ChipEnable && WaitInit == 4'd0) begin
            go = 1'b1;
        end else if (state == WAIT && ce_i == ChipEnable && count <= 4'd1) begin
            go = 1'b1;
        end

`ifdef DATA_RAM_ERR_EN
        legal = sel_is_legal(cur_sel);
`else
        legal = 1'b1;
`endif

        bank_we = 4'b0000;
        if (go && cur_we == WriteEnable && legal) begin
            bank_we = cur_sel;
        end
        // Reads return the full word whatever the lane select says.
        bank_re = go && (cur_we != WriteEnable);
    end

    assign stallreq_o = ce_i & ~ack_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            ack_o    <= 1'b0;
            req_we   <= 1'b0;
            req_addr <= '0;
            req_sel  <= 4'b0000;
            req_data <= ZeroWord;
        end else begin
            ack_o <= go;
            case (state)
                IDLE: begin
                    if (ce_i == ChipEnable) begin
                        req_we   <= we_i;
                        req_addr <= addr_i[ADDR_W+1:2];
                        req_sel  <= sel_i;
                        req_data <= data_i;
                        count    <= WaitInit;
                        state    <= (WaitInit == 4'd0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (ce_i != ChipEnable) begin
                        // Requester gave up: abandon without touching memory.
                        count <= 4'd0;
                        state <= IDLE;
                    end else if (count <= 4'd1) begin
                        count <= 4'd0;
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_RAM_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= go & ~legal;
        end
    end
`endif

    data_ram_bank #(
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .re    (bank_re),
        .addr  (cur_addr),
        .wdata (cur_data),
        .rdata (data_o)
    );

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the number of 32-bit words stored (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the number of wait states inserted before each access completes.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset rst, synchronous, active-high.
REQ-005 SHALL have port ce_i, input, 1, access request (chip enable).
REQ-006 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port addr_i, input, 32, byte address.
REQ-008 SHALL have port sel_i, input, 4, byte-lane select; bit 3 selects data[31:24] (byte offset 00, big-endian).
REQ-009 SHALL have port data_i, input, 32, write data, already lane-aligned by the requester.
REQ-010 SHALL have port data_o, output, 32, registered read word.
REQ-011 SHALL have port ack_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port stallreq_o, output, 1, pipeline hold request.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE with ce_i=1 SHALL capture we_i/addr_i/sel_i/data_i into request registers, load the wait counter with WAIT_CYCLES, and go to WAIT; if WAIT_CYCLES=0 it SHALL go directly to DONE.
REQ-015 WAIT SHALL decrement the counter each cycle and go to DONE on the cycle the counter reaches 0.
REQ-016 The transition into DONE SHALL perform the access: writes update only lanes with sel=1; reads load the full word into data_o regardless of sel.
REQ-017 In DONE, ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL go unconditionally to IDLE.
REQ-018 Latency SHALL be WAIT_CYCLES+1 cycles from acceptance to ack_o.
REQ-019 stallreq_o SHALL be combinational: ce_i & ~ack_o.
REQ-020 The word index SHALL be addr_i[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes; addr_i[1:0] is ignored.
REQ-021 If ce_i falls while in WAIT, the access SHALL abort, with no write, no ack, and a return to IDLE.
REQ-022 A write with sel_i=0000 SHALL modify nothing and SHALL still be acked.
REQ-023 data_o SHALL hold its value until the next completed read; writes SHALL NOT change it.
REQ-024 Back-to-back accesses SHALL be possible: a new request is accepted in the IDLE cycle following DONE.

Reset
REQ-025 On rst: state=IDLE, counter=0, ack_o=0, data_o=0, and the request registers=0.
REQ-026 rst during WAIT SHALL abort the access with no write.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 Macro DATA_RAM_ERR_EN defined: the module SHALL add port err_o (output, 1), pulsed together with ack_o when the captured sel is not one of 1000, 0100, 0010, 0001, 1100, 0011, 0111, 1110, 1111.
REQ-029 With DATA_RAM_ERR_EN defined, an illegal-sel write SHALL write nothing, and an illegal-sel read SHALL still update data_o.
REQ-030 Macro DATA_RAM_ERR_EN undefined: err_o SHALL be absent and every sel pattern SHALL be honored lane by lane.

Structure
REQ-031 A shared package SHALL hold the state enum, the legal-sel constants, and the ZeroWord/ChipEnable/WriteEnable constants.
REQ-032 A sub-module data_ram_bank SHALL hold four byte-wide arrays with per-lane write enable and a synchronous word read.

Verification
REQ-033 WAIT_CYCLES=1: write addr 0x10, sel 1111, data 0xDEADBEEF, then read 0x10 -> ack 2 cycles after accept, stallreq high 2 cycles, data_o=0xDEADBEEF.
REQ-034 Word 0x10 holds 0xDEADBEEF; write sel 0100, data 0x00AA0000 -> a read returns 0xDEAABEEF.
REQ-035 WAIT_CYCLES=0, ADDR_W=10: write 0x11223344 to addr 0x1000 -> a read of addr 0x0 returns 0x11223344 (wrap), with ack 1 cycle after accept.
REQ-036 WAIT_CYCLES=3: drop ce_i in the second WAIT cycle of a write -> no ack, memory unchanged, state returns to IDLE; repeat the test with rst in place of the ce_i drop.
REQ-037 DATA_RAM_ERR_EN defined: write sel 0110 -> err_o=1 with ack_o, memory unchanged; a read with sel 1100 -> err_o=0.
